dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = pipeline load/store unit, port 1 = debug/DMA loader.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_addr_check.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory port arbiter: owner-state encoding,
// port indices and the byte size of the legal address window.
package dmem_arb_pkg;

  // Owner FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Requester indices: 0 = load/store unit, 1 = debug/DMA loader
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Owner state that serves the given port
  function automatic logic [1:0] own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

  // Bytes covered by a word-indexed memory of the given depth
  function automatic logic [31:0] window_bytes(input int depth);
    return 32'(4 * depth);
  endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational range/alignment check of the owner's byte address and the
// BASE-relative offset presented to the data memory.
module dmem_addr_check #(
  parameter int                ADDR_W       = 32,
  parameter int                MEMORY_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              addr_ok_o,
  output logic [ADDR_W-1:0] offset_o
);
  import dmem_arb_pkg::*;

  localparam logic [ADDR_W-1:0] WINDOW = ADDR_W'(window_bytes(MEMORY_DEPTH));

  // Offset is always passed on; legality needs lower bound, window and alignment.
  always_comb begin
    offset_o  = addr_i - BASE_ADDR;
    addr_ok_o = (addr_i >= BASE_ADDR) && (offset_o < WINDOW) && (addr_i[1:0] == 2'b00);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = pipeline load/store unit, port 1 = debug/DMA loader.
// Registered owner FSM, combinational grant from the owner's request,
// registered read return, bounded bursts with lock, address window check.
// Optional feature: define DMEM_ARB_RR_EN for round-robin choice in IDLE;
// otherwise port 0 wins IDLE contention.
module dmem_port_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
  parameter int                    MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  P0_Req_i,
  input  logic                  P0_Write_i,
  input  logic                  P0_Lock_i,
  input  logic [DATA_WIDTH-1:0] P0_Addr_i,
  input  logic [DATA_WIDTH-1:0] P0_Wdata_i,
  output logic                  P0_Gnt_o,
  output logic                  P0_Rvalid_o,
  output logic [DATA_WIDTH-1:0] P0_Rdata_o,
  output logic                  P0_Err_o,
  input  logic                  P1_Req_i,
  input  logic                  P1_Write_i,
  input  logic                  P1_Lock_i,
  input  logic [DATA_WIDTH-1:0] P1_Addr_i,
  input  logic [DATA_WIDTH-1:0] P1_Wdata_i,
  output logic                  P1_Gnt_o,
  output logic                  P1_Rvalid_o,
  output logic [DATA_WIDTH-1:0] P1_Rdata_o,
  output logic                  P1_Err_o,
  output logic                  Mem_Write_o,
  output logic                  Mem_Read_o,
  output logic [DATA_WIDTH-1:0] Mem_Addr_o,
  output logic [DATA_WIDTH-1:0] Mem_Wdata_o,
  input  logic [DATA_WIDTH-1:0] Mem_Rdata_i
);
  import dmem_arb_pkg::*;

  localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  // Per-port views so both requesters share one description
  logic [1:0]            req_v, wr_v, lock_v, gnt_v, rvalid_v, err_v;
  logic [DATA_WIDTH-1:0] addr_v  [2];
  logic [DATA_WIDTH-1:0] wdata_v [2];
  logic [DATA_WIDTH-1:0] rdata_v [2];

  assign req_v      = {P1_Req_i, P0_Req_i};
  assign wr_v       = {P1_Write_i, P0_Write_i};
  assign lock_v     = {P1_Lock_i, P0_Lock_i};
  assign addr_v[0]  = P0_Addr_i;
  assign addr_v[1]  = P1_Addr_i;
  assign wdata_v[0] = P0_Wdata_i;
  assign wdata_v[1] = P1_Wdata_i;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             owner_valid, owner, other, idle_pick, any_gnt;
  logic             sel_write, addr_ok;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata, mem_offset;

  assign owner_valid = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign owner       = (state_q == ST_OWN1);
  assign other       = ~owner;
  assign sel_addr    = addr_v[owner];
  assign sel_wdata   = wdata_v[owner];
  assign sel_write   = wr_v[owner];
  assign any_gnt     = |gnt_v;

  dmem_addr_check #(
    .ADDR_W       (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .BASE_ADDR    (BASE_ADDR)
  ) u_addr_check (
    .addr_i    (sel_addr),
    .addr_ok_o (addr_ok),
    .offset_o  (mem_offset)
  );

  // Illegal accesses are still granted but never reach the memory.
  assign Mem_Write_o = any_gnt &&  sel_write && addr_ok;
  assign Mem_Read_o  = any_gnt && !sel_write && addr_ok;
  assign Mem_Addr_o  = mem_offset;
  assign Mem_Wdata_o = sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // Track the last served port so IDLE contention alternates.
  always_comb begin
    rr_last_d = rr_last_q;
    if (any_gnt) rr_last_d = owner;
  end

  // Last-served register; port 1 after reset so port 0 goes first.
  always_ff @(posedge clk) begin
    if (!reset) rr_last_q <= PORT1;
    else        rr_last_q <= rr_last_d;
  end

  assign idle_pick = ~rr_last_q;
`else
  assign idle_pick = PORT0;
`endif

  // Owner selection: idle arbitration, release on drop, handover after a burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_v[0] && req_v[1]) state_d = own_state(idle_pick);
        else if (req_v[0])        state_d = ST_OWN0;
        else if (req_v[1])        state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (!req_v[owner])
          state_d = req_v[other] ? own_state(other) : ST_IDLE;
        else if (req_v[other] && !lock_v[owner] && (beat_cnt_q >= BEAT_LAST))
          state_d = own_state(other);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat counter saturates so a locked owner can hold indefinitely.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d != state_q)
      beat_cnt_d = '0;
    else if (any_gnt && (beat_cnt_q != BEAT_LAST))
      beat_cnt_d = beat_cnt_q + 1'b1;
  end

  // Owner state and burst length registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  rvalid_q, rerr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign gnt_v[gi] = owner_valid && (owner == 1'(gi)) && req_v[gi];

    // Read return one cycle after the grant; illegal reads return zero data.
    always_ff @(posedge clk) begin
      if (!reset) begin
        rvalid_q <= 1'b0;
        rerr_q   <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt_v[gi] && !wr_v[gi];
        if (gnt_v[gi] && !wr_v[gi]) begin
          rdata_q <= addr_ok ? Mem_Rdata_i : '0;
          rerr_q  <= !addr_ok;
        end
      end
    end

    assign rvalid_v[gi] = rvalid_q;
    assign rdata_v[gi]  = rdata_q;
    // Read errors ride with Rvalid; write errors pulse with the grant.
    assign err_v[gi]    = (rvalid_q && rerr_q) || (gnt_v[gi] && wr_v[gi] && !addr_ok);
  end

  assign P0_Gnt_o    = gnt_v[0];
  assign P0_Rvalid_o = rvalid_v[0];
  assign P0_Rdata_o  = rdata_v[0];
  assign P0_Err_o    = err_v[0];
  assign P1_Gnt_o    = gnt_v[1];
  assign P1_Rvalid_o = rvalid_v[1];
  assign P1_Rdata_o  = rdata_v[1];
  assign P1_Err_o    = err_v[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-indexed memory model.
module tb_dmem_port_arbiter;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0, reset = 1'b0;
  logic        p0_req = 0, p0_write = 0, p0_lock = 0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 0, p1_write = 0, p1_lock = 0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .P0_Req_i(p0_req), .P0_Write_i(p0_write), .P0_Lock_i(p0_lock),
    .P0_Addr_i(p0_addr), .P0_Wdata_i(p0_wdata),
    .P0_Gnt_o(p0_gnt), .P0_Rvalid_o(p0_rvalid), .P0_Rdata_o(p0_rdata), .P0_Err_o(p0_err),
    .P1_Req_i(p1_req), .P1_Write_i(p1_write), .P1_Lock_i(p1_lock),
    .P1_Addr_i(p1_addr), .P1_Wdata_i(p1_wdata),
    .P1_Gnt_o(p1_gnt), .P1_Rvalid_o(p1_rvalid), .P1_Rdata_o(p1_rdata), .P1_Err_o(p1_err),
    .Mem_Write_o(mem_write), .Mem_Read_o(mem_read), .Mem_Addr_o(mem_addr),
    .Mem_Wdata_o(mem_wdata), .Mem_Rdata_i(mem_rdata)
  );

  // Data memory model: pattern A500_00nn per word, reloaded on reset
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc(); smp();
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read} !== 8'h00) begin
      errors++; $display("FAIL rst_outputs: got %b want 00000000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read}); end
    checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata); end
    cyc(); reset = 1'b1;
    p0_req = 1; p0_write = 0; p0_addr = BASE + 32'h8;
    smp();
    checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL rst_idle_gnt: got %b want 0", p0_gnt); end
    cyc(); smp();
    checks++; if (p0_gnt !== 1'b1 || mem_read !== 1'b1) begin
      errors++; $display("FAIL rst_pre_gnt: got gnt=%b rd=%b want 1/1", p0_gnt, mem_read); end
    reset = 1'b0;
    cyc(); smp();
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read} !== 8'h00) begin
      errors++; $display("FAIL rst_midread: got %b want 00000000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read}); end
    checks++; if (p0_rdata !== 32'h0) begin errors++; $display("FAIL rst_midread_rdata: got %h want 0", p0_rdata); end
    p0_req = 0;
    cyc(); reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    cyc();
    p0_req = 1; p0_write = 1; p0_addr = BASE + 32'h4; p0_wdata = 32'hDEAD_BEEF;
    smp();
    checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL wr_latency: got %b want 0", p0_gnt); end
    cyc(); smp();
    checks++; if (p0_gnt !== 1'b1 || mem_write !== 1'b1 || p0_err !== 1'b0) begin
      errors++; $display("FAIL wr_gnt: got gnt=%b we=%b err=%b want 1/1/0", p0_gnt, mem_write, p0_err); end
    checks++; if (mem_addr !== 32'h4 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_bus: got addr=%h data=%h want 4/deadbeef", mem_addr, mem_wdata); end
    cyc(); p0_write = 0;
    smp();
    checks++; if (p0_gnt !== 1'b1 || mem_read !== 1'b1 || p0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_gnt: got gnt=%b rd=%b rv=%b want 1/1/0", p0_gnt, mem_read, p0_rvalid); end
    cyc(); p0_req = 0;
    smp();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p0_err !== 1'b0) begin
      errors++; $display("FAIL rd_return: got rv=%b data=%h err=%b want 1/deadbeef/0", p0_rvalid, p0_rdata, p0_err); end
    cyc(); smp();
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", p0_rvalid); end
    $display("test_write_read done");
  endtask

  task automatic test_burst();
    logic exp0, prev0, prev1;
    prev0 = 0; prev1 = 0;
    cyc();
    p0_req = 1; p0_write = 0; p0_addr = BASE + 32'h10;
    p1_req = 1; p1_write = 0; p1_addr = BASE + 32'h20;
    smp();
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL burst_idle: got %b%b want 00", p0_gnt, p1_gnt); end
    for (int k = 0; k < 16; k++) begin
      cyc(); smp();
      exp0 = ((k / 4) % 2) == 0;
      checks++; if (p0_gnt !== exp0 || p1_gnt !== !exp0) begin
        errors++; $display("FAIL burst_gnt[%0d]: got p0=%b p1=%b want p0=%b p1=%b", k, p0_gnt, p1_gnt, exp0, !exp0); end
      if (k > 0) begin
        checks++; if (p0_rvalid !== prev0 || p1_rvalid !== prev1) begin
          errors++; $display("FAIL burst_rv[%0d]: got %b%b want %b%b", k, p0_rvalid, p1_rvalid, prev0, prev1); end
      end
      if (k == 1) begin
        checks++; if (p0_rdata !== 32'hA500_0004) begin errors++; $display("FAIL burst_p0_data: got %h want a5000004", p0_rdata); end
      end
      if (k == 4) begin
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL burst_p1_addr: got %h want 20", mem_addr); end
      end
      if (k == 5) begin
        checks++; if (p1_rdata !== 32'hA500_0008) begin errors++; $display("FAIL burst_p1_data: got %h want a5000008", p1_rdata); end
      end
      prev0 = exp0; prev1 = !exp0;
    end
    cyc(); p0_req = 0; p1_req = 0;
    smp();
    checks++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL burst_end: got rv=%b%b gnt=%b%b want 01/00", p0_rvalid, p1_rvalid, p0_gnt, p1_gnt); end
    $display("test_burst done");
  endtask

  task automatic test_lock();
    cyc();
    p0_req = 1; p0_lock = 1; p0_write = 0; p0_addr = BASE + 32'h10;
    p1_req = 1; p1_write = 0; p1_addr = BASE + 32'h20;
    smp();
    for (int k = 0; k < 10; k++) begin
      cyc(); smp();
      checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d]: got p0=%b p1=%b want 1/0", k, p0_gnt, p1_gnt); end
    end
    cyc(); p0_req = 0; p0_lock = 0;
    smp();
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || p0_rvalid !== 1'b1) begin
      errors++; $display("FAIL lock_drop: got gnt=%b%b rv0=%b want 00/1", p0_gnt, p1_gnt, p0_rvalid); end
    cyc(); smp();
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL lock_handover: got %b want 1", p1_gnt); end
    cyc(); p1_req = 0;
    smp();
    checks++; if (p1_rvalid !== 1'b1 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL lock_p1_rv: got rv=%b gnt=%b want 1/0", p1_rvalid, p1_gnt); end
    $display("test_lock done");
  endtask

  task automatic test_range();
    cyc();
    p1_req = 1; p1_write = 0; p1_addr = BASE + 32'h400;
    smp();
    cyc(); smp();
    checks++; if (p1_gnt !== 1'b1 || mem_read !== 1'b0 || p1_err !== 1'b0) begin
      errors++; $display("FAIL oob_rd_gnt: got gnt=%b rd=%b err=%b want 1/0/0", p1_gnt, mem_read, p1_err); end
    cyc(); p1_req = 0;
    smp();
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0 || p1_err !== 1'b1) begin
      errors++; $display("FAIL oob_rd_ret: got rv=%b data=%h err=%b want 1/0/1", p1_rvalid, p1_rdata, p1_err); end
    cyc();
    p1_req = 1; p1_write = 1; p1_addr = 32'h0; p1_wdata = 32'h1234;
    smp();
    checks++; if (p1_err !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL oob_err_clear: got err=%b gnt=%b want 0/0", p1_err, p1_gnt); end
    cyc(); smp();
    checks++; if (p1_gnt !== 1'b1 || p1_err !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'hEFFF_0000) begin
      errors++; $display("FAIL oob_wr: got gnt=%b err=%b we=%b addr=%h want 1/1/0/efff0000", p1_gnt, p1_err, mem_write, mem_addr); end
    cyc(); p1_req = 0; p1_write = 0;
    smp();
    checks++; if (p1_err !== 1'b0) begin errors++; $display("FAIL oob_wr_pulse: got %b want 0", p1_err); end
    cyc();
    p0_req = 1; p0_write = 0; p0_addr = BASE + 32'h3FC;
    smp();
    cyc(); smp();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h3FC) begin
      errors++; $display("FAIL last_word_rd: got rd=%b addr=%h want 1/3fc", mem_read, mem_addr); end
    cyc(); p0_req = 0;
    smp();
    checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'hA500_00FF) begin
      errors++; $display("FAIL last_word_ret: got rv=%b err=%b data=%h want 1/0/a50000ff", p0_rvalid, p0_err, p0_rdata); end
    $display("test_range done");
  endtask

  task automatic test_contention();
    logic exp0, want_p1;
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    p0_req = 1; p0_write = 0; p0_addr = BASE;
    p1_req = 1; p1_write = 0; p1_addr = BASE + 32'h4;
    smp();
    for (int k = 0; k < 8; k++) begin
      cyc(); smp();
      exp0 = (k < 4);
      checks++; if (p0_gnt !== exp0 || p1_gnt !== !exp0) begin
        errors++; $display("FAIL cont_gnt[%0d]: got p0=%b p1=%b want p0=%b p1=%b", k, p0_gnt, p1_gnt, exp0, !exp0); end
    end
    cyc(); p0_req = 0; p1_req = 0;
    cyc(); p0_req = 1;
    smp();
    cyc(); smp();
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL cont_solo: got %b want 1", p0_gnt); end
    cyc(); p0_req = 0;
    cyc(); p0_req = 1; p1_req = 1;
    smp();
`ifdef DMEM_ARB_RR_EN
    want_p1 = 1'b1;
`else
    want_p1 = 1'b0;
`endif
    cyc(); smp();
    checks++; if (p1_gnt !== want_p1 || p0_gnt !== !want_p1) begin
      errors++; $display("FAIL cont_second: got p0=%b p1=%b want p0=%b p1=%b", p0_gnt, p1_gnt, !want_p1, want_p1); end
    cyc(); p0_req = 0; p1_req = 0;
    smp();
    $display("test_contention done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_lock();
    test_range();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
